// File: rtl/dt_result_scan.sv
// Result-memory scanner: after a rising edge on start, reads every byte of the
// distance-transform result once in raster order and reduces it to statistics.
module dt_result_scan #(
  parameter int IMG_PIX = 16384,
  parameter int ADDR_W  = 14,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              res_rd,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [7:0]        res_di,
  output logic              busy,
  output logic              scan_done,
  output logic [7:0]        max_dist,
  output logic [ADDR_W-1:0] max_addr,
  output logic [14:0]       obj_count,
  output logic [21:0]       dist_sum,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIX - 1);

  state_t            state_q;
  logic              start_q;
  logic              busy_q;
  logic              scan_done_q;
  logic [7:0]        max_dist_q;
  logic [ADDR_W-1:0] max_addr_q;
  logic [14:0]       obj_count_q;
  logic [21:0]       dist_sum_q;

  // Read tag pipeline: stage 0 is the read being issued this cycle (it drives
  // res_rd/res_addr directly); stage RD_LAT-1 lines up with valid res_di.
  logic [RD_LAT-1:0] tag_vld_q;
  logic [ADDR_W-1:0] tag_addr_q [RD_LAT];

  logic              trig;
  logic              cap_vld;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_new_max;

  always_comb begin
    trig        = start & ~start_q;
    cap_vld     = tag_vld_q[RD_LAT-1];
    cap_addr    = tag_addr_q[RD_LAT-1];
    cap_new_max = res_di > max_dist_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
      max_dist_q  <= '0;
      max_addr_q  <= '0;
      obj_count_q <= '0;
      dist_sum_q  <= '0;
      tag_vld_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_addr_q[i] <= '0;
    end else begin
      start_q <= start;

      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_addr_q[i] <= tag_addr_q[i-1];
      end

      // Strict compare keeps the lowest address on ties.
      if (cap_vld) begin
        dist_sum_q <= dist_sum_q + {14'd0, res_di};
        if (res_di != 8'd0) obj_count_q <= obj_count_q + 15'd1;
        if (cap_new_max) begin
          max_dist_q <= res_di;
          max_addr_q <= cap_addr;
        end
      end

      case (state_q)
        IDLE, DONE: begin
          if (trig) begin
            state_q       <= READ;
            busy_q        <= 1'b1;
            scan_done_q   <= 1'b0;
            max_dist_q    <= '0;
            max_addr_q    <= '0;
            obj_count_q   <= '0;
            dist_sum_q    <= '0;
            tag_vld_q[0]  <= 1'b1;
            tag_addr_q[0] <= '0;
          end
        end
        READ: begin
          if (tag_addr_q[0] == LAST_ADDR) begin
            state_q       <= DRAIN;
            tag_vld_q[0]  <= 1'b0;
            tag_addr_q[0] <= '0;
          end else begin
            tag_addr_q[0] <= tag_addr_q[0] + 1'b1;
          end
        end
        DRAIN: begin
          if (tag_vld_q == '0) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            scan_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_rd      = tag_vld_q[0];
  assign res_addr    = tag_addr_q[0];
  assign busy        = busy_q;
  assign scan_done   = scan_done_q;
  assign max_dist    = max_dist_q;
  assign max_addr    = max_addr_q;
  assign obj_count   = obj_count_q;
  assign dist_sum    = dist_sum_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dt_result_scan.sv
// Directed bench for dt_result_scan: two instances (RD_LAT=1 and RD_LAT=3)
// scanning separate memory models from a shared start/reset.
module tb_dt_result_scan;

  localparam int IMG_PIX = 16384;
  localparam int ADDR_W  = 14;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic              rd1, rd3, busy1, busy3, sd1, sd3;
  logic [ADDR_W-1:0] addr1, addr3, ma1, ma3;
  logic [7:0]        di1, di3, md1, md3;
  logic [14:0]       oc1, oc3;
  logic [21:0]       ds1, ds3;
  logic [1:0]        st1, st3;

  logic [7:0] mem1 [IMG_PIX];
  logic [7:0] mem3 [IMG_PIX];

  // RD_LAT=1 memory: data valid in the issue cycle.
  assign di1 = rd1 ? mem1[addr1] : 8'hA5;

  // RD_LAT=3 memory: two-cycle delayed address/strobe.
  logic              rd3_d1, rd3_d2;
  logic [ADDR_W-1:0] a3_d1, a3_d2;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd3_d1 <= 1'b0; rd3_d2 <= 1'b0; a3_d1 <= '0; a3_d2 <= '0;
    end else begin
      rd3_d1 <= rd3; a3_d1 <= addr3;
      rd3_d2 <= rd3_d1; a3_d2 <= a3_d1;
    end
  end
  assign di3 = rd3_d2 ? mem3[a3_d2] : 8'h5A;

  dt_result_scan #(.IMG_PIX(IMG_PIX), .ADDR_W(ADDR_W), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start),
    .res_rd(rd1), .res_addr(addr1), .res_di(di1),
    .busy(busy1), .scan_done(sd1), .max_dist(md1), .max_addr(ma1),
    .obj_count(oc1), .dist_sum(ds1), .dbg_state_o(st1)
  );

  dt_result_scan #(.IMG_PIX(IMG_PIX), .ADDR_W(ADDR_W), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start),
    .res_rd(rd3), .res_addr(addr3), .res_di(di3),
    .busy(busy3), .scan_done(sd3), .max_dist(md3), .max_addr(ma3),
    .obj_count(oc3), .dist_sum(ds3), .dbg_state_o(st3)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // 0 = all zero, 1 = single 7 at 8321, 2 = 5@100,5@200,4@50, 3 = all 255
  function automatic logic [7:0] pat_val(input int pat, input int a);
    case (pat)
      1:       return (a == 8321) ? 8'd7 : 8'd0;
      2:       return (a == 100 || a == 200) ? 8'd5 : ((a == 50) ? 8'd4 : 8'd0);
      3:       return 8'd255;
      default: return 8'd0;
    endcase
  endfunction

  task automatic exp_of(input int pat, output int md, output int ma, output int oc, output int ds);
    case (pat)
      1:       begin md = 7;   ma = 8321; oc = 1;     ds = 7;       end
      2:       begin md = 5;   ma = 100;  oc = 3;     ds = 14;      end
      3:       begin md = 255; ma = 0;    oc = 16384; ds = 4177920; end
      default: begin md = 0;   ma = 0;    oc = 0;     ds = 0;       end
    endcase
  endtask

  task automatic load(input int which, input int pat);
    for (int i = 0; i < IMG_PIX; i++) begin
      if (which == 1) mem1[i] = pat_val(pat, i);
      else            mem3[i] = pat_val(pat, i);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd1"}, rd1, 0);     check({tag, "_rd3"}, rd3, 0);
    check({tag, "_addr1"}, addr1, 0); check({tag, "_addr3"}, addr3, 0);
    check({tag, "_busy1"}, busy1, 0); check({tag, "_busy3"}, busy3, 0);
    check({tag, "_sd1"}, sd1, 0);     check({tag, "_sd3"}, sd3, 0);
    check({tag, "_md1"}, md1, 0);     check({tag, "_md3"}, md3, 0);
    check({tag, "_ma1"}, ma1, 0);     check({tag, "_ma3"}, ma3, 0);
    check({tag, "_oc1"}, oc1, 0);     check({tag, "_oc3"}, oc3, 0);
    check({tag, "_ds1"}, ds1, 0);     check({tag, "_ds3"}, ds3, 0);
    check({tag, "_st1"}, st1, 0);     check({tag, "_st3"}, st3, 0);
  endtask

  // n counts cycles after the trigger edge T: sample n is cycle T+n.
  task automatic run_scan(input string tag, input bit raise, input int p1, input int p3);
    int n, bc1, bc3, rc1, rc3, ae1, ae3, ea1, ea3, dn1, dn3, f1, f3;
    int md, ma, oc, ds;
    n = 0; bc1 = 0; bc3 = 0; rc1 = 0; rc3 = 0; ae1 = 0; ae3 = 0;
    ea1 = 0; ea3 = 0; dn1 = 0; dn3 = 0; f1 = 0; f3 = 0;
    if (raise) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    while ((dn1 == 0 || dn3 == 0) && n < 20000) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check({tag, "_sdclr1"}, sd1, 0);  check({tag, "_sdclr3"}, sd3, 0);
        check({tag, "_busy_on1"}, busy1, 1); check({tag, "_busy_on3"}, busy3, 1);
      end
      if (busy1) bc1++;
      if (busy3) bc3++;
      if (rd1) begin
        if (f1 == 0) f1 = n;
        if (addr1 !== ADDR_W'(ea1)) ae1++;
        ea1++; rc1++;
      end
      if (rd3) begin
        if (f3 == 0) f3 = n;
        if (addr3 !== ADDR_W'(ea3)) ae3++;
        ea3++; rc3++;
      end
      if (sd1 && dn1 == 0) dn1 = n;
      if (sd3 && dn3 == 0) dn3 = n;
    end
    check({tag, "_done_at1"}, dn1, IMG_PIX + 2);
    check({tag, "_done_at3"}, dn3, IMG_PIX + 4);
    check({tag, "_busy_cyc1"}, bc1, IMG_PIX + 1);
    check({tag, "_busy_cyc3"}, bc3, IMG_PIX + 3);
    check({tag, "_rd_cnt1"}, rc1, IMG_PIX);
    check({tag, "_rd_cnt3"}, rc3, IMG_PIX);
    check({tag, "_addr_err1"}, ae1, 0);
    check({tag, "_addr_err3"}, ae3, 0);
    check({tag, "_first_rd1"}, f1, 1);
    check({tag, "_first_rd3"}, f3, 1);
    check({tag, "_end_addr1"}, addr1, 0);
    check({tag, "_end_addr3"}, addr3, 0);
    check({tag, "_state1"}, st1, 3);
    check({tag, "_state3"}, st3, 3);
    exp_of(p1, md, ma, oc, ds);
    check({tag, "_max_dist1"}, md1, md);
    check({tag, "_max_addr1"}, ma1, ma);
    check({tag, "_obj_cnt1"}, oc1, oc);
    check({tag, "_dist_sum1"}, ds1, ds);
    exp_of(p3, md, ma, oc, ds);
    check({tag, "_max_dist3"}, md3, md);
    check({tag, "_max_addr3"}, ma3, ma);
    check({tag, "_obj_cnt3"}, oc3, oc);
    check({tag, "_dist_sum3"}, ds3, ds);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int spins;

    // Reset state.
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;

    // Scan 1 aborted by reset at address 5000, then restarted with start held.
    load(1, 0);
    load(3, 1);
    @(negedge clk);
    start = 1'b1;
    spins = 0;
    while (!(rd1 && addr1 == ADDR_W'(5000)) && spins < 6000) begin
      @(negedge clk);
      spins++;
    end
    check("abort_reached", addr1, 5000);
    reset = 1'b0;
    #1;
    check_zero("abort");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_scan("s1", 1'b0, 0, 1);

    // Scan 2: tie pattern on RD_LAT=1, all-255 on RD_LAT=3.
    @(negedge clk);
    start = 1'b0;
    load(1, 2);
    load(3, 3);
    run_scan("s2", 1'b1, 2, 3);

    // start stays high: no retrigger, outputs hold.
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rd1 || rd3 || busy1 || busy3) n++;
    end
    check("hold_no_activity", n, 0);
    check("hold_sd1", sd1, 1);
    check("hold_sd3", sd3, 1);
    check("hold_ds3", ds3, 4177920);

    // Drop and raise again: identical results.
    start = 1'b0;
    @(negedge clk);
    run_scan("s3", 1'b1, 2, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
